debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
Multi-channel key debouncer for the digital clock user interface. It replaces the single-key debouncer.
- One tick generator is shared by all N_KEYS channels.
- Each channel has a 2-FF synchronizer and a tick-sampled FSM.
- Each channel produces a debounced level, a press pulse and a release pulse.
- Each channel can optionally produce auto-repeat pulses on long hold, used for fast time setting.

Parameters:
N_KEYS, 4, number of independent key channels (>=1)
TICK_DIV, 500000, sample tick period in clk_i cycles (>=2)
STABLE_TICKS, 3, consecutive equal samples needed to accept a press or release (>=2)
HOLD_TICKS, 100, ticks held after acceptance before the first repeat (>=1)
REPEAT_TICKS, 20, ticks between subsequent repeats (>=1)
CNT_W, 32, width of tick divider and per-channel counters

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset; one clock, reset asynchronous, active-low
key_i  in  N_KEYS  raw asynchronous key inputs, active-high
repeat_en_i  in  N_KEYS  per-channel auto-repeat enable
level_o  out  N_KEYS  debounced key level
press_o  out  N_KEYS  1-cycle pulse on accepted press
release_o  out  N_KEYS  1-cycle pulse on accepted release
repeat_o  out  N_KEYS  1-cycle pulse per auto-repeat event

Behaviour:
- Reset (rst_ni=0, asynchronous) clears all state:
  - all outputs 0, all counters 0, synchronizers 0, every channel in IDLE;
  - effective immediately, including mid-press; no release_o is emitted for a key held across reset.
- Tick generator:
  - div counts 0..TICK_DIV-1 and wraps to 0;
  - tick=1 in exactly the cycle div==TICK_DIV-1;
  - first tick occurs TICK_DIV cycles after reset release.
- Synchronizer: key_s = key_i delayed 2 flops. The FSM only ever sees key_s.
- Per-channel FSM. States: IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT. All transitions happen only on tick cycles, except pulse clearing.
  - IDLE: key_s=1 -> PRESS_WAIT, cnt=1.
  - PRESS_WAIT:
    - key_s=0 -> IDLE;
    - otherwise cnt++;
    - when cnt+1==STABLE_TICKS -> HELD, level_o=1, press_o pulse, hold=0.
  - HELD:
    - key_s=0 -> RELEASE_WAIT, cnt=1;
    - otherwise hold++;
    - if repeat_en_i=1 and hold+1==HOLD_TICKS -> REPEAT, repeat_o pulse, hold=0;
    - if repeat_en_i=0, hold saturates at HOLD_TICKS-1.
  - REPEAT:
    - key_s=0 -> RELEASE_WAIT, cnt=1;
    - repeat_en_i=0 -> HELD, hold=0, no pulse;
    - otherwise hold++; when hold+1==REPEAT_TICKS -> repeat_o pulse, hold=0.
  - RELEASE_WAIT:
    - key_s=1 -> HELD, hold=0, level_o stays 1, no pulse;
    - otherwise cnt++;
    - when cnt+1==STABLE_TICKS -> IDLE, level_o=0, release_o pulse.
- Output registers:
  - press_o, release_o and repeat_o are high exactly for the cycle after the accepting tick cycle, then 0;
  - level_o changes in that same cycle.
- Priority: key_s=0 in HELD/REPEAT takes precedence over a repeat in the same tick.
- Latency: a clean press becomes press_o after 2 cycles plus between STABLE_TICKS-1 and STABLE_TICKS tick periods plus 1 cycle.
- Channels are fully independent. Simultaneous events on several channels assert their pulses in the same cycle.
- repeat_en_i is sampled on tick cycles only.

Decomposition:
- Package debounce_pkg holds:
  - typedef enum logic [2:0] deb_state_t {IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT};
  - no other shared constants.
- Sub-module debounce_chan is one channel: synchronizer, FSM, cnt/hold counters and registered outputs. It takes tick as an input.
- debounce_multi contains the tick generator and a generate loop of N_KEYS debounce_chan instances.

Test Plan:
Bench settings: N_KEYS=2, TICK_DIV=4, STABLE_TICKS=3, HOLD_TICKS=5, REPEAT_TICKS=2. "Tick k" means the k-th tick after the key change.
1. Reset:
   - rst_ni=0 at any time, including with level_o[0]=1 -> all outputs 0 within the same cycle;
   - after release, no pulses while key_i=0.
2. Clean press and release, repeat_en_i=0:
   - key_i[0]=1 held 20 cycles -> press_o[0] one pulse and level_o[0]=1 the cycle after the 3rd high tick;
   - then key_i[0]=0 -> release_o[0] one pulse, level_o[0]=0 after 3 low ticks.
3. Bounce: key_i[0] high for exactly 2 ticks then low -> press_o=0 and level_o=0 throughout.
4. Auto-repeat:
   - repeat_en_i[0]=1, key held -> press at tick 3;
   - repeat_o[0] pulses after ticks 8, 10, 12, ...;
   - after release, exactly one release_o pulse.
5. Release glitch: in HELD, one low tick then high -> no release_o, level_o stays 1, hold restarts.
6. Independence:
   - key_i=2'b11 at the same cycle -> both press_o bits pulse in the same cycle;
   - key_i[1] bouncing while key_i[0] is held -> key 1 never pulses and key 0 behaviour is unchanged.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types for the multi-channel key debouncer.
package debounce_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      REPEAT,
      RELEASE_WAIT
   } deb_state_t;

endpackage

// File: rtl/debounce_chan.sv
// One key channel: 2-FF synchronizer, tick-sampled debounce FSM with
// optional auto-repeat, and registered level/press/release/repeat outputs.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int STABLE_TICKS = 3,
   parameter int HOLD_TICKS   = 100,
   parameter int REPEAT_TICKS = 20,
   parameter int CNT_W        = 32
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic tick_i,
   input  logic key_i,
   input  logic repeat_en_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic repeat_o
);

   // "cnt+1 == N" is tested as "cnt == N-1" so no adder sits in the compare.
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_TICKS - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
   localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

   logic [1:0]       sync_q;
   logic             key_s;
   deb_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] hold_q;

   assign key_s = sync_q[1];

   // NOTE: every register here uses non-blocking assignment so all flops
   // update together from pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], key_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hold_q    <= '0;
         level_o   <= 1'b0;
         press_o   <= 1'b0;
         release_o <= 1'b0;
         repeat_o  <= 1'b0;
      end else begin
         // NOTE: pulses default low every cycle; a branch below raises one
         // for exactly the cycle following the accepting tick.
         press_o   <= 1'b0;
         release_o <= 1'b0;
         repeat_o  <= 1'b0;
         if (tick_i) begin
            case (state_q)
               IDLE: begin
                  if (key_s) begin
                     state_q <= PRESS_WAIT;
                     cnt_q   <= ONE;
                  end
               end
               PRESS_WAIT: begin
                  if (!key_s) begin
                     state_q <= IDLE;
                  end else if (cnt_q == STABLE_LAST) begin
                     state_q <= HELD;
                     level_o <= 1'b1;
                     press_o <= 1'b1;
                     hold_q  <= '0;
                  end else begin
                     cnt_q <= cnt_q + ONE;
                  end
               end
               HELD: begin
                  // A low sample wins over a repeat due on the same tick.
                  if (!key_s) begin
                     state_q <= RELEASE_WAIT;
                     cnt_q   <= ONE;
                  end else if (hold_q == HOLD_LAST) begin
                     if (repeat_en_i) begin
                        state_q  <= REPEAT;
                        repeat_o <= 1'b1;
                        hold_q   <= '0;
                     end
                  end else begin
                     hold_q <= hold_q + ONE;
                  end
               end
               REPEAT: begin
                  if (!key_s) begin
                     state_q <= RELEASE_WAIT;
                     cnt_q   <= ONE;
                  end else if (!repeat_en_i) begin
                     state_q <= HELD;
                     hold_q  <= '0;
                  end else if (hold_q == REPEAT_LAST) begin
                     repeat_o <= 1'b1;
                     hold_q   <= '0;
                  end else begin
                     hold_q <= hold_q + ONE;
                  end
               end
               RELEASE_WAIT: begin
                  if (key_s) begin
                     state_q <= HELD;
                     hold_q  <= '0;
                  end else if (cnt_q == STABLE_LAST) begin
                     state_q   <= IDLE;
                     level_o   <= 1'b0;
                     release_o <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + ONE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel key debouncer: one shared sample-tick divider feeding
// N_KEYS independent debounce channels.
module debounce_multi #(
   parameter int N_KEYS       = 4,
   parameter int TICK_DIV     = 500000,
   parameter int STABLE_TICKS = 3,
   parameter int HOLD_TICKS   = 100,
   parameter int REPEAT_TICKS = 20,
   parameter int CNT_W        = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [N_KEYS-1:0] key_i,
   input  logic [N_KEYS-1:0] repeat_en_i,
   output logic [N_KEYS-1:0] level_o,
   output logic [N_KEYS-1:0] press_o,
   output logic [N_KEYS-1:0] release_o,
   output logic [N_KEYS-1:0] repeat_o
);

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] div_q;
   logic             tick;

   assign tick = (div_q == DIV_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q <= '0;
      end else if (tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
      debounce_chan #(
         .STABLE_TICKS (STABLE_TICKS),
         .HOLD_TICKS   (HOLD_TICKS),
         .REPEAT_TICKS (REPEAT_TICKS),
         .CNT_W        (CNT_W)
      ) u_chan (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .tick_i      (tick),
         .key_i       (key_i[g]),
         .repeat_en_i (repeat_en_i[g]),
         .level_o     (level_o[g]),
         .press_o     (press_o[g]),
         .release_o   (release_o[g]),
         .repeat_o    (repeat_o[g])
      );
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: run-length behavioural model with
// per-cycle comparison, plus literal pulse-timing expectations per scenario.
module tb_debounce_multi;

   localparam int N_KEYS       = 2;
   localparam int TICK_DIV     = 4;
   localparam int STABLE_TICKS = 3;
   localparam int HOLD_TICKS   = 5;
   localparam int REPEAT_TICKS = 2;
   localparam int CNT_W        = 8;

   logic              clk_i  = 1'b0;
   logic              rst_ni = 1'b0;
   logic [N_KEYS-1:0] key_i       = '0;
   logic [N_KEYS-1:0] repeat_en_i = '0;
   logic [N_KEYS-1:0] level_o, press_o, release_o, repeat_o;

   always #5 clk_i = ~clk_i;

   debounce_multi #(
      .N_KEYS       (N_KEYS),
      .TICK_DIV     (TICK_DIV),
      .STABLE_TICKS (STABLE_TICKS),
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .CNT_W        (CNT_W)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .key_i       (key_i),
      .repeat_en_i (repeat_en_i),
      .level_o     (level_o),
      .press_o     (press_o),
      .release_o   (release_o),
      .repeat_o    (repeat_o)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: n counts clock edges since reset release; a tick is every
   // TICK_DIV-th edge; the key seen on an edge is key_i from two edges
   // earlier. Debouncing is a run-length count of samples that disagree with
   // the current level; repeats fall HOLD ticks after the press (or glitch
   // recovery) and every REPEAT ticks after that.
   int                n;
   int                tick_no;
   logic [N_KEYS-1:0] hist1, hist2;
   logic [N_KEYS-1:0] exp_level, exp_press, exp_release, exp_repeat;
   int                run    [N_KEYS];
   int                anchor [N_KEYS];

   task automatic model_sample(input int ch, input logic s, input logic en);
      int d;
      if (!exp_level[ch]) begin
         if (s) begin
            run[ch]++;
            if (run[ch] == STABLE_TICKS) begin
               exp_level[ch] = 1'b1;
               exp_press[ch] = 1'b1;
               run[ch]       = 0;
               anchor[ch]    = tick_no;
            end
         end else begin
            run[ch] = 0;
         end
      end else if (!s) begin
         run[ch]++;
         if (run[ch] == STABLE_TICKS) begin
            exp_level[ch]   = 1'b0;
            exp_release[ch] = 1'b1;
            run[ch]         = 0;
         end
      end else if (run[ch] > 0) begin
         run[ch]    = 0;
         anchor[ch] = tick_no;
      end else if (en) begin
         d = tick_no - anchor[ch];
         if (d == HOLD_TICKS || (d > HOLD_TICKS && (d - HOLD_TICKS) % REPEAT_TICKS == 0))
            exp_repeat[ch] = 1'b1;
      end
   endtask

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         n = 0; tick_no = 0;
         hist1 = '0; hist2 = '0;
         exp_level = '0; exp_press = '0; exp_release = '0; exp_repeat = '0;
         for (int ch = 0; ch < N_KEYS; ch++) begin
            run[ch] = 0; anchor[ch] = 0;
         end
      end else begin
         exp_press = '0; exp_release = '0; exp_repeat = '0;
         if (n % TICK_DIV == TICK_DIV - 1) begin
            tick_no++;
            for (int ch = 0; ch < N_KEYS; ch++) model_sample(ch, hist2[ch], repeat_en_i[ch]);
         end
         hist2 = hist1;
         hist1 = key_i;
         n++;
      end
   end

   // Per-cycle compare and pulse statistics; statistics clear during reset.
   int press_cnt [N_KEYS], release_cnt [N_KEYS], repeat_cnt [N_KEYS], level_hi [N_KEYS];
   int first_press [N_KEYS], last_press [N_KEYS], first_release [N_KEYS], last_release [N_KEYS];
   int first_repeat [N_KEYS];

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         for (int ch = 0; ch < N_KEYS; ch++) begin
            press_cnt[ch] = 0; release_cnt[ch] = 0; repeat_cnt[ch] = 0; level_hi[ch] = 0;
            first_press[ch] = -1; last_press[ch] = -1; first_release[ch] = -1;
            last_release[ch] = -1; first_repeat[ch] = -1;
         end
      end else begin
         check("level_o",   32'(level_o),   32'(exp_level));
         check("press_o",   32'(press_o),   32'(exp_press));
         check("release_o", 32'(release_o), 32'(exp_release));
         check("repeat_o",  32'(repeat_o),  32'(exp_repeat));
         for (int ch = 0; ch < N_KEYS; ch++) begin
            if (level_o[ch]) level_hi[ch]++;
            if (press_o[ch]) begin
               press_cnt[ch]++;
               if (first_press[ch] < 0) first_press[ch] = n;
               last_press[ch] = n;
            end
            if (release_o[ch]) begin
               release_cnt[ch]++;
               if (first_release[ch] < 0) first_release[ch] = n;
               last_release[ch] = n;
            end
            if (repeat_o[ch]) begin
               repeat_cnt[ch]++;
               if (first_repeat[ch] < 0) first_repeat[ch] = n;
            end
         end
      end
   end

   task automatic start_test(input logic [N_KEYS-1:0] en);
      @(negedge clk_i); #2;
      rst_ni = 1'b0; key_i = '0; repeat_en_i = en;
      @(negedge clk_i); @(negedge clk_i); #2;
      rst_ni = 1'b1;
   endtask

   task automatic wait_to(input int k);
      while (n < k) @(negedge clk_i);
   endtask

   function automatic int total_pulses();
      return press_cnt[0] + press_cnt[1] + release_cnt[0] + release_cnt[1]
           + repeat_cnt[0] + repeat_cnt[1];
   endfunction

   initial begin
      // 1a: reset state and quiet after release
      start_test('0);
      check("reset_state", 32'({level_o, press_o, release_o, repeat_o}), 32'h0);
      wait_to(30);
      check("idle_no_pulses", total_pulses(), 0);

      // 2: clean press and release
      start_test('0);
      wait_to(6);  key_i[0] = 1'b1;
      wait_to(26); key_i[0] = 1'b0;
      wait_to(44);
      check("clean_press_at",   first_press[0], 20);
      check("clean_release_at", first_release[0], 40);
      check("clean_press_cnt",  press_cnt[0], 1);
      check("clean_rel_cnt",    release_cnt[0], 1);
      check("clean_rep_cnt",    repeat_cnt[0], 0);
      check("clean_level_len",  level_hi[0], 20);

      // 3: bounce of exactly two high ticks
      start_test('0);
      wait_to(6);  key_i[0] = 1'b1;
      wait_to(14); key_i[0] = 1'b0;
      wait_to(40);
      check("bounce_press_cnt", press_cnt[0], 0);
      check("bounce_level_hi",  level_hi[0], 0);

      // 4: auto-repeat
      start_test(2'b01);
      wait_to(6);  key_i[0] = 1'b1;
      wait_to(58); key_i[0] = 1'b0;
      wait_to(80);
      check("rep_press_at",     first_press[0], 20);
      check("rep_first_at",     first_repeat[0], 40);
      check("rep_cnt",          repeat_cnt[0], 3);
      check("rep_release_cnt",  release_cnt[0], 1);
      check("rep_release_at",   first_release[0], 72);

      // 5: one-tick release glitch restarts the hold count
      start_test(2'b01);
      wait_to(6);  key_i[0] = 1'b1;
      wait_to(26); key_i[0] = 1'b0;
      wait_to(30); key_i[0] = 1'b1;
      wait_to(60);
      check("glitch_release_cnt", release_cnt[0], 0);
      check("glitch_first_rep",   first_repeat[0], 56);
      check("glitch_rep_cnt",     repeat_cnt[0], 1);
      check("glitch_level",       32'(level_o[0]), 1);

      // 6: independence
      start_test('0);
      wait_to(6);  key_i = 2'b11;
      wait_to(26); key_i = 2'b00;
      wait_to(44);
      check("both_press0_at", first_press[0], 20);
      check("both_press1_at", first_press[1], 20);
      check("both_rel1_at",   first_release[1], 40);
      key_i[0] = 1'b1;
      while (n < 100) begin
         key_i[1] = ((n - 44) % 6) < 3;
         @(negedge clk_i);
      end
      key_i = 2'b00;
      wait_to(120);
      check("indep_press1_cnt", press_cnt[1], 1);
      check("indep_rel1_cnt",   release_cnt[1], 1);
      check("indep_level1_len", level_hi[1], 20);
      check("indep_press0_at",  last_press[0], 56);
      check("indep_rel0_at",    last_release[0], 112);

      // 1b: asynchronous reset while a key is held
      start_test('0);
      wait_to(6); key_i[0] = 1'b1;
      wait_to(24);
      check("pre_reset_level", 32'(level_o[0]), 1);
      @(posedge clk_i); #1;
      rst_ni = 1'b0;
      #1;
      check("async_reset_outputs", 32'({level_o, press_o, release_o, repeat_o}), 32'h0);
      @(negedge clk_i); @(negedge clk_i); #2;
      key_i = '0; rst_ni = 1'b1;
      wait_to(30);
      check("post_reset_no_pulses", total_pulses(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
